// File: rtl/bcd_timer_pkg.sv
// Shared definitions for the BCD stopwatch, count-down timer and display driver.
// Holds the ctrl encodings, the BCD digit type and a load-value cleanup helper.
package bcd_timer_pkg;

  localparam logic [1:0] CTRL_HOLD  = 2'b00;
  localparam logic [1:0] CTRL_LOAD  = 2'b01;
  localparam logic [1:0] CTRL_RUN   = 2'b10;
  localparam logic [1:0] CTRL_HOLD2 = 2'b11;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  // Out-of-range load digits either clamp to 9 or collapse to 0.
  function automatic bcd_digit_t clean_digit(input bcd_digit_t d, input bit sat);
    if (d > BCD_MAX) return sat ? BCD_MAX : bcd_digit_t'(0);
    return d;
  endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit of a decrement borrow chain: q = d - bin, wrapping 0 -> 9.
// bout is raised only when a borrow arrives at a digit that is already 0.
module bcd_digit_dec
  import bcd_timer_pkg::*;
(
  input  bcd_digit_t d,
  input  logic       bin,
  output bcd_digit_t q,
  output logic       bout
);

  always_comb begin
    q    = d;
    bout = 1'b0;
    if (bin) begin
      if (d == 4'd0) begin
        q    = BCD_MAX;
        bout = 1'b1;
      end else begin
        q = d - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// BCD count-down timer (s.ms.mms): load, then decrement one hundredth per
// rising edge of slowclk until 0.00, flagging expiry and pulsing done_pulse.
module bcd_countdown_timer
  import bcd_timer_pkg::*;
#(
  parameter bit AUTO_RELOAD = 1'b0,
  parameter bit SAT_LOAD    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       slowclk,
  input  logic [1:0] ctrl,
  input  logic [3:0] ld_s,
  input  logic [3:0] ld_ms,
  input  logic [3:0] ld_mms,
  output logic [3:0] Osout,
  output logic [3:0] Omsout,
  output logic [3:0] Ommsout,
  output logic       running,
  output logic       expired,
  output logic       done_pulse
);

  bcd_digit_t s_q, ms_q, mms_q;
  bcd_digit_t s_rl, ms_rl, mms_rl;
  bcd_digit_t s_dec, ms_dec, mms_dec;
  bcd_digit_t s_ld, ms_ld, mms_ld;
  logic       prev_slow;
  logic       tick;
  logic       mms_bout, ms_bout, s_bout;
  logic       count_zero, dec_zero, load_zero, reload_zero;

  assign tick = slowclk & ~prev_slow;

  bcd_digit_dec u_dec_mms (.d(mms_q), .bin(1'b1),     .q(mms_dec), .bout(mms_bout));
  bcd_digit_dec u_dec_ms  (.d(ms_q),  .bin(mms_bout), .q(ms_dec),  .bout(ms_bout));
  bcd_digit_dec u_dec_s   (.d(s_q),   .bin(ms_bout),  .q(s_dec),   .bout(s_bout));

  // A borrow falls out of the whole chain exactly when the count is 0.00.
  assign count_zero  = s_bout;
  assign dec_zero    = ({s_dec, ms_dec, mms_dec} == 12'h000);

  assign s_ld        = clean_digit(ld_s,   SAT_LOAD);
  assign ms_ld       = clean_digit(ld_ms,  SAT_LOAD);
  assign mms_ld      = clean_digit(ld_mms, SAT_LOAD);
  assign load_zero   = ({s_ld, ms_ld, mms_ld} == 12'h000);
  assign reload_zero = ({s_rl, ms_rl, mms_rl} == 12'h000);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q        <= '0;
      ms_q       <= '0;
      mms_q      <= '0;
      s_rl       <= '0;
      ms_rl      <= '0;
      mms_rl     <= '0;
      prev_slow  <= 1'b0;
      expired    <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      prev_slow  <= slowclk;
      done_pulse <= 1'b0;
      case (ctrl)
        CTRL_LOAD: begin
          s_q     <= s_ld;
          ms_q    <= ms_ld;
          mms_q   <= mms_ld;
          s_rl    <= s_ld;
          ms_rl   <= ms_ld;
          mms_rl  <= mms_ld;
          expired <= load_zero;
        end
        CTRL_RUN: begin
          if (tick) begin
            if (!count_zero) begin
              s_q   <= s_dec;
              ms_q  <= ms_dec;
              mms_q <= mms_dec;
              if (dec_zero) begin
                expired    <= 1'b1;
                done_pulse <= 1'b1;
              end
            end else if (AUTO_RELOAD) begin
              s_q     <= s_rl;
              ms_q    <= ms_rl;
              mms_q   <= mms_rl;
              expired <= reload_zero;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign Osout   = s_q;
  assign Omsout  = ms_q;
  assign Ommsout = mms_q;
  assign running = (ctrl == CTRL_RUN) && !expired;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer: one instance with default parameters
// and one with AUTO_RELOAD=1, both driven by the same stimulus.
module tb_bcd_countdown_timer;
  import bcd_timer_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       slowclk = 1'b0;
  logic [1:0] ctrl = CTRL_HOLD;
  logic [3:0] ld_s = '0, ld_ms = '0, ld_mms = '0;

  logic [3:0] s_o, ms_o, mms_o;
  logic       running, expired, done_pulse;
  logic [3:0] ar_s_o, ar_ms_o, ar_mms_o;
  logic       ar_running, ar_expired, ar_done_pulse;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;
  int ar_pulses = 0;
  logic hi_done, hi_ar_done;

  bcd_countdown_timer #(.AUTO_RELOAD(1'b0), .SAT_LOAD(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .slowclk(slowclk), .ctrl(ctrl),
    .ld_s(ld_s), .ld_ms(ld_ms), .ld_mms(ld_mms),
    .Osout(s_o), .Omsout(ms_o), .Ommsout(mms_o),
    .running(running), .expired(expired), .done_pulse(done_pulse)
  );

  bcd_countdown_timer #(.AUTO_RELOAD(1'b1), .SAT_LOAD(1'b1)) dut_ar (
    .clk(clk), .rst_n(rst_n), .slowclk(slowclk), .ctrl(ctrl),
    .ld_s(ld_s), .ld_ms(ld_ms), .ld_mms(ld_mms),
    .Osout(ar_s_o), .Omsout(ar_ms_o), .Ommsout(ar_mms_o),
    .running(ar_running), .expired(ar_expired), .done_pulse(ar_done_pulse)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [11:0] cnt();
    return {s_o, ms_o, mms_o};
  endfunction

  function automatic logic [11:0] ar_cnt();
    return {ar_s_o, ar_ms_o, ar_mms_o};
  endfunction

  // driver tasks
  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      pulses    += int'(done_pulse);
      ar_pulses += int'(ar_done_pulse);
    end
  endtask

  task automatic do_load(input logic [3:0] s, input logic [3:0] ms, input logic [3:0] mms);
    ctrl = CTRL_LOAD; ld_s = s; ld_ms = ms; ld_mms = mms;
    cycle(1);
    ctrl = CTRL_HOLD;
  endtask

  // One slowclk pulse, high for one clk and low for one clk.
  task automatic tick();
    slowclk = 1'b1;
    cycle(1);
    hi_done    = done_pulse;
    hi_ar_done = ar_done_pulse;
    slowclk = 1'b0;
    cycle(1);
  endtask

  initial begin
    #12;
    check("reset_digits", 32'(cnt()), 32'h000);
    check("reset_expired", 32'(expired), 0);
    check("reset_done", 32'(done_pulse), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(2);

    // 1: 1.05 down to 0.00
    do_load(4'd1, 4'd0, 4'd5);
    check("t1_load", 32'(cnt()), 32'h105);
    check("t1_load_expired", 32'(expired), 0);
    ctrl = CTRL_RUN;
    #1;
    check("t1_running", 32'(running), 1);
    pulses = 0;
    for (int k = 1; k <= 105; k++) begin
      tick();
      check($sformatf("t1_tick%0d", k), 32'(cnt()), 32'(to_bcd(105 - k)));
    end
    check("t1_pulses", 32'(pulses), 1);
    check("t1_pulse_on_last", 32'(hi_done), 1);
    check("t1_expired", 32'(expired), 1);
    check("t1_not_running", 32'(running), 0);

    // 2: hold freezes and consumes edges
    do_load(4'd0, 4'd1, 4'd0);
    ctrl = CTRL_RUN;
    tick();
    check("t2_first", 32'(cnt()), 32'h009);
    ctrl = CTRL_HOLD;
    repeat (3) tick();
    check("t2_hold", 32'(cnt()), 32'h009);
    ctrl = CTRL_RUN;
    cycle(2);
    check("t2_no_replay", 32'(cnt()), 32'h009);
    pulses = 0;
    repeat (9) tick();
    check("t2_end", 32'(cnt()), 32'h000);
    check("t2_expired", 32'(expired), 1);
    check("t2_pulses", 32'(pulses), 1);

    // 3: load 0.00
    do_load(4'd0, 4'd0, 4'd0);
    check("t3_expired", 32'(expired), 1);
    check("t3_done", 32'(done_pulse), 0);
    ctrl = CTRL_RUN;
    pulses = 0;
    repeat (3) tick();
    check("t3_stays", 32'(cnt()), 32'h000);
    check("t3_pulses", 32'(pulses), 0);
    check("t3_expired_after", 32'(expired), 1);

    // 4: auto reload
    do_load(4'd0, 4'd0, 4'd2);
    ctrl = CTRL_RUN;
    ar_pulses = 0;
    tick();
    check("t4_ar_001", 32'(ar_cnt()), 32'h001);
    check("t4_ar_exp0", 32'(ar_expired), 0);
    tick();
    check("t4_ar_000", 32'(ar_cnt()), 32'h000);
    check("t4_ar_pulse", 32'(hi_ar_done), 1);
    check("t4_ar_exp1", 32'(ar_expired), 1);
    tick();
    check("t4_ar_reload", 32'(ar_cnt()), 32'h002);
    check("t4_ar_exp_fall", 32'(ar_expired), 0);
    check("t4_ar_no_pulse", 32'(hi_ar_done), 0);
    check("t4_ar_pulses", 32'(ar_pulses), 1);
    check("t4_plain_stays", 32'(cnt()), 32'h000);

    // 5: saturating load, load beats tick
    do_load(4'd3, 4'hC, 4'hF);
    check("t5_sat", 32'(cnt()), 32'h399);
    ctrl = CTRL_RUN;
    tick();
    check("t5_dec", 32'(cnt()), 32'h398);
    ctrl = CTRL_LOAD; ld_s = 4'd2; ld_ms = 4'd5; ld_mms = 4'd5;
    slowclk = 1'b1;
    cycle(1);
    check("t5_load_wins", 32'(cnt()), 32'h255);
    check("t5_load_done", 32'(done_pulse), 0);
    ctrl = CTRL_RUN;
    cycle(2);
    check("t5_edge_consumed", 32'(cnt()), 32'h255);
    slowclk = 1'b0;
    cycle(1);

    // 6: asynchronous reset mid-count
    do_load(4'd0, 4'd4, 4'd0);
    ctrl = CTRL_RUN;
    repeat (3) tick();
    check("t6_037", 32'(cnt()), 32'h037);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_rst_digits", 32'(cnt()), 32'h000);
    check("t6_rst_expired", 32'(expired), 0);
    check("t6_rst_ar_digits", 32'(ar_cnt()), 32'h000);
    cycle(2);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    ar_pulses = 0;
    cycle(3);
    tick();
    check("t6_no_pulse", 32'(pulses), 0);
    check("t6_ar_no_pulse", 32'(ar_pulses), 0);
    check("t6_digits_after", 32'(cnt()), 32'h000);
    check("t6_expired_after", 32'(expired), 0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
